keypad_emulator: RTL and testbench

- Synthesizable 3x3 key-matrix responder: the far end of the column-scan / row-sense interface used by the keypad scanner.
- Watches the scanner's one-hot column drive and returns row lines as if a physical key were pressed, with programmable contact bounce, hold time and inter-press gap.
- Used for board self-test and auto-play: a request source (test sequencer or light-position echo) submits key indices, and the emulator plays them into the scanner's row inputs.

---
 rtl/keypad_emulator.sv | 207 ++++++++++++++++++++
 tb/tb_keypad_emulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: emulates the far end of a 3x3 column-scan / row-sense key matrix.
// The scanner drives a one-hot column. The emulator answers on the row lines as if
// the requested key were physically pressed. Each press has make bounce, a stable
// hold, break bounce and an open gap before the next request is taken.
//
// Ports:
//   clk       system clock (CLOCK_50)
//   reset     synchronous, active-low
//   column    one-hot active-high column drive from the scanner
//   row       active-high row sense back to the scanner (combinational)
//   req_valid press request valid; the requester holds it until req_ready
//   req_key   key index 0..8 (row = key/3, column = key%3)
//   req_ready high only while idle
//   abort     forces an immediate release from MAKE/HOLD/BREAK
//   busy      high whenever not idle
//   contact   current emulated switch state
//   done      one-cycle pulse when a press sequence completes
//   err       one-cycle pulse after an out-of-range key is offered
module keypad_emulator #(
    parameter int unsigned CNT_W         = 28,
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned BOUNCE_CYCLES = 500_000,
    parameter int unsigned BOUNCE_TOGGLE = 50_000,
    parameter int unsigned GAP_CYCLES    = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] column,
    output logic [2:0] row,
    input  logic       req_valid,
    input  logic [3:0] req_key,
    output logic       req_ready,
    input  logic       abort,
    output logic       busy,
    output logic       contact,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {StIdle, StMake, StHold, StBreak, StGap} state_e;

    localparam bit NoBounce = (BOUNCE_CYCLES == 0);
    localparam bit NoGap    = (GAP_CYCLES == 0);

    // Last counter value of each phase; zero-length phases are never entered.
    localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BounceLast = NoBounce ? '0 : CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ToggleLast = CNT_W'(BOUNCE_TOGGLE - 1);
    localparam logic [CNT_W-1:0] GapLast    = NoGap ? '0 : CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tog_q, tog_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             contact_q, contact_d;
    logic [3:0]       key_q, key_d;
    logic             err_q, err_d;
    logic             enter_gap;
    logic [2:0]       row_oh, col_oh;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        contact_d = contact_q;
        key_d     = key_q;
        err_d     = 1'b0;
        enter_gap = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_key <= 4'd8) begin
                        key_d     = req_key;
                        cnt_d     = '0;
                        tog_d     = '0;
                        contact_d = 1'b1;
                        state_d   = NoBounce ? StHold : StMake;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StMake: begin
                if (abort) begin
                    enter_gap = 1'b1;
                end else if (cnt_q == BounceLast) begin
                    state_d   = StHold;
                    cnt_d     = '0;
                    tog_d     = '0;
                    contact_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (tog_q == ToggleLast) begin
                        tog_d     = '0;
                        contact_d = ~contact_q;
                    end else begin
                        tog_d = tog_q + CNT_W'(1);
                    end
                end
            end
            StHold: begin
                if (abort) begin
                    enter_gap = 1'b1;
                end else if (cnt_q == HoldLast) begin
                    if (NoBounce) begin
                        enter_gap = 1'b1;
                    end else begin
                        state_d   = StBreak;
                        cnt_d     = '0;
                        tog_d     = '0;
                        contact_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StBreak: begin
                if (abort || (cnt_q == BounceLast)) begin
                    enter_gap = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (tog_q == ToggleLast) begin
                        tog_d     = '0;
                        contact_d = ~contact_q;
                    end else begin
                        tog_d = tog_q + CNT_W'(1);
                    end
                    // The final break cycle always reads open, whatever the toggle phase.
                    if (cnt_inc == BounceLast) begin
                        contact_d = 1'b0;
                    end
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase

        // Common release path (normal end or abort). With no gap the press
        // completes on this very cycle.
        if (enter_gap) begin
            state_d   = NoGap ? StIdle : StGap;
            cnt_d     = '0;
            tog_d     = '0;
            contact_d = 1'b0;
            done      = NoGap;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            tog_q     <= '0;
            contact_q <= 1'b0;
            key_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            contact_q <= contact_d;
            key_q     <= key_d;
            err_q     <= err_d;
        end
    end

    // Matrix position of the latched key as one-hot row and column.
    always_comb begin
        row_oh = 3'b000;
        col_oh = 3'b000;
        case (key_q)
            4'd0: begin row_oh = 3'b001; col_oh = 3'b001; end
            4'd1: begin row_oh = 3'b001; col_oh = 3'b010; end
            4'd2: begin row_oh = 3'b001; col_oh = 3'b100; end
            4'd3: begin row_oh = 3'b010; col_oh = 3'b001; end
            4'd4: begin row_oh = 3'b010; col_oh = 3'b010; end
            4'd5: begin row_oh = 3'b010; col_oh = 3'b100; end
            4'd6: begin row_oh = 3'b100; col_oh = 3'b001; end
            4'd7: begin row_oh = 3'b100; col_oh = 3'b010; end
            4'd8: begin row_oh = 3'b100; col_oh = 3'b100; end
            default: begin
                row_oh = 3'b000;
                col_oh = 3'b000;
            end
        endcase
    end

    // Only the key's own column bit matters, so a non-one-hot drive still
    // answers whenever that bit is set.
    assign row       = (contact_q && |(column & col_oh)) ? row_oh : 3'b000;
    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign contact   = contact_q;
    assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] column;
    logic       req_valid, req_valid0;
    logic [3:0] req_key;
    logic       abort;
    logic       abort0;

    logic [2:0] row, row0;
    logic       req_ready, busy, contact, done, err;
    logic       req_ready0, busy0, contact0, done0, err0;

    always #5 clk = ~clk;

    keypad_emulator #(
        .CNT_W(8), .HOLD_CYCLES(8), .BOUNCE_CYCLES(4), .BOUNCE_TOGGLE(1), .GAP_CYCLES(3)
    ) u_dut (
        .clk(clk), .reset(reset), .column(column), .row(row),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .abort(abort), .busy(busy), .contact(contact), .done(done), .err(err)
    );

    keypad_emulator #(
        .CNT_W(8), .HOLD_CYCLES(8), .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(1), .GAP_CYCLES(3)
    ) u_dut0 (
        .clk(clk), .reset(reset), .column(column), .row(row0),
        .req_valid(req_valid0), .req_key(req_key), .req_ready(req_ready0),
        .abort(abort0), .busy(busy0), .contact(contact0), .done(done0), .err(err0)
    );

    typedef struct {
        string      tag;
        logic       sel;
        logic [7:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // {row, contact, busy, req_ready, done, err}
    function automatic logic [7:0] pack(logic [2:0] r, logic c, logic b, logic rdy,
                                        logic d, logic e);
        return {r, c, b, rdy, d, e};
    endfunction

    // Expected contact k cycles after acceptance (k=0 is the accepting cycle),
    // for HOLD=8, BOUNCE=4, TOGGLE=1, GAP=3.
    function automatic logic press_contact(int k);
        if (k >= 1 && k <= 4) return (k % 2 == 1);
        if (k >= 5 && k <= 12) return 1'b1;
        if (k == 14) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic press_busy(int k);
        return (k >= 1 && k <= 19);
    endfunction

    task automatic push(string tag, logic sel, logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.vec = v;
        sb_q.push_back(e);
    endtask

    // Expected vector for the main DUT during a standard press, row answering rowhit.
    task automatic push_press(string tag, int k, logic [2:0] rowhit);
        logic c;
        c = press_contact(k);
        push(tag, 1'b0, pack(c ? rowhit : 3'b000, c, press_busy(k), !press_busy(k),
                             k == 19, 1'b0));
    endtask

    // Sample at the falling edge, compare against the scoreboard head, then
    // advance to just after the next rising edge.
    task automatic tick();
        exp_t       e;
        logic [7:0] obs;
        @(negedge clk);
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard: observed empty queue, required an entry");
        end else begin
            e   = sb_q.pop_front();
            obs = e.sel ? pack(row0, contact0, busy0, req_ready0, done0, err0)
                        : pack(row, contact, busy, req_ready, done, err);
            assert (obs === e.vec) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b (row,contact,busy,ready,done,err)",
                       e.tag, obs, e.vec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rot [3];

    initial begin
        rot[0] = 3'b001;
        rot[1] = 3'b010;
        rot[2] = 3'b100;
        reset = 1'b0; column = 3'b010; req_valid = 1'b0; req_valid0 = 1'b0;
        req_key = 4'd0; abort = 1'b0; abort0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state of both instances.
        push("reset", 1'b0, pack(3'b000, 0, 0, 1, 0, 0));
        tick();
        push("reset_nb", 1'b1, pack(3'b000, 0, 0, 1, 0, 0));
        tick();

        // Key 4 with column 010: full bounce/hold/break/gap timeline.
        req_key = 4'd4;
        for (int k = 0; k <= 20; k++) begin
            req_valid = (k == 0);
            push_press($sformatf("key4_k%0d", k), k, 3'b010);
            tick();
        end

        // Key 7 with rotating column: answers only while column=010.
        req_key = 4'd7;
        for (int k = 0; k <= 20; k++) begin
            logic c;
            req_valid = (k == 0);
            column    = rot[k % 3];
            c         = press_contact(k);
            push($sformatf("key7_k%0d", k), 1'b0,
                 pack((c && column == 3'b010) ? 3'b100 : 3'b000, c, press_busy(k),
                      !press_busy(k), k == 19, 1'b0));
            tick();
        end

        // Out-of-range key: one err pulse, stays idle.
        column    = 3'b010;
        req_key   = 4'd12;
        req_valid = 1'b1;
        push("badkey_req", 1'b0, pack(3'b000, 0, 0, 1, 0, 0));
        tick();
        req_valid = 1'b0;
        push("badkey_err", 1'b0, pack(3'b000, 0, 0, 1, 0, 1));
        tick();
        push("badkey_after", 1'b0, pack(3'b000, 0, 0, 1, 0, 0));
        tick();

        // Abort during HOLD at k=7: straight to a 3-cycle gap.
        req_key = 4'd4;
        for (int k = 0; k <= 11; k++) begin
            req_valid = (k == 0);
            abort     = (k == 7);
            if (k <= 7)
                push_press($sformatf("abort_k%0d", k), k, 3'b010);
            else if (k <= 10)
                push($sformatf("abort_k%0d", k), 1'b0, pack(3'b000, 0, 1, 0, k == 10, 0));
            else
                push("abort_idle", 1'b0, pack(3'b000, 0, 0, 1, 0, 0));
            tick();
        end
        abort = 1'b0;

        // Request held valid across a press: second accepted on first idle cycle.
        req_key = 4'd0;
        column  = 3'b001;
        for (int k = 0; k <= 40; k++) begin
            req_valid = (k <= 20);
            push_press($sformatf("b2b_k%0d", k), (k <= 20) ? k : k - 20, 3'b001);
            tick();
        end
        req_valid = 1'b0;

        // Reset mid-HOLD releases at that edge.
        req_key = 4'd4;
        column  = 3'b010;
        for (int k = 0; k <= 9; k++) begin
            req_valid = (k == 0);
            reset     = (k != 7);
            if (k <= 7)
                push_press($sformatf("rst_k%0d", k), k, 3'b010);
            else
                push($sformatf("rst_k%0d", k), 1'b0, pack(3'b000, 0, 0, 1, 0, 0));
            tick();
        end
        reset = 1'b1;

        // No-bounce instance: clean 8-cycle contact then 3-cycle gap.
        for (int j = 0; j <= 12; j++) begin
            logic c, b;
            req_valid0 = (j == 0);
            c = (j >= 1 && j <= 8);
            b = (j >= 1 && j <= 11);
            push($sformatf("nobounce_j%0d", j), 1'b1,
                 pack(c ? 3'b010 : 3'b000, c, b, !b, j == 11, 1'b0));
            tick();
        end
        req_valid0 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
